// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer states, frame geometry and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with extra-bit pointers so full and empty are distinguishable.
module byte_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (count == (AW+1)'(DEPTH));
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Byte-stream 8N1 UART transmitter: valid/ready into a FIFO, back-to-back frames on RsTx.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   data_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic                         RsTx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         frame_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  tx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              frame_done_q, frame_done_d;
  logic              bit_end;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;

  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_in),
    .pop   (fifo_pop),
    .din   (data_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;
    bit_end      = (clk_cnt_q == CNT_W'(CLKS_PER_BIT-1));
    if (state_q != IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          tx_d      = 1'b0;
          clk_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(DATA_BITS-1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        // Registered pulse, so it is armed one clk ahead to land on the last stop clk.
        frame_done_d = (clk_cnt_q == CNT_W'(CLKS_PER_BIT-2));
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign RsTx       = tx_q;
  assign frame_done = frame_done_q;
  assign ready_out  = !fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: a line monitor decodes every frame and checks it against a byte scoreboard.
module tb_uart_tx_stream;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, RsTx, busy, frame_done;
  logic [4:0] fifo_count;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q [$];

  int         cyc = 0;
  int         pos = 0;
  int         frames_seen = 0;
  int         start_cyc [64];
  int         end_cyc [64];
  logic       samp [FRAME];
  logic       mon_ok;
  logic [7:0] mon_byte;
  logic [7:0] exp_byte;
  logic [7:0] lb [5] = '{8'h00, 8'hFF, 8'h55, 8'h08, 8'h10};
  int         fs0;

  uart_tx_stream #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .RsTx       (RsTx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Line monitor: samples mid-cycle, checks each level lasts exactly CPB clks, pops the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pos = 0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(pos == FRAME-1));
      if (pos != 0 || RsTx == 1'b0) begin
        if (pos == 0 && frames_seen < 64) start_cyc[frames_seen] = cyc;
        samp[pos] = RsTx;
        pos++;
        if (pos == FRAME) begin
          pos    = 0;
          mon_ok = (samp[0] === 1'b0) && (samp[FRAME-CPB] === 1'b1);
          for (int j = 0; j < 10; j++)
            for (int k = 0; k < CPB; k++)
              if (samp[j*CPB+k] !== samp[j*CPB]) mon_ok = 1'b0;
          for (int b = 0; b < 8; b++) mon_byte[b] = samp[(b+1)*CPB];
          chk("frame_shape", 32'(mon_ok), 32'd1);
          chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            exp_byte = exp_q.pop_front();
            chk("rx_byte", 32'(mon_byte), 32'(exp_byte));
          end
          if (frames_seen < 64) end_cyc[frames_seen] = cyc;
          frames_seen++;
        end
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames_seen < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("frames_seen", 32'(frames_seen), 32'(n));
  endtask

  task automatic wait_fd(input int budget);
    int t = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_RsTx", 32'(RsTx), 32'd1);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single byte 0xA5, latency and busy release
    @(posedge clk); #1 data_in = 8'hA5; valid_in = 1'b1; exp_q.push_back(8'hA5);
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    chk("push_count", 32'(fifo_count), 32'd1);
    chk("push_busy", 32'(busy), 32'd1);
    chk("no_fallthrough", 32'(RsTx), 32'd1);
    @(negedge clk);
    chk("start_latency", 32'(RsTx), 32'd0);
    chk("pop_count", 32'(fifo_count), 32'd0);
    wait_fd(200);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("idle_line", 32'(RsTx), 32'd1);
    wait_frames(1, 50);

    // Burst into full FIFO: 17 accepted, then gapless drain
    fs0 = frames_seen;
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 data_in = 8'(i); valid_in = 1'b1;
      @(negedge clk);
      chk("burst_ready", 32'(ready_out), 32'(i <= 16));
      chk("burst_count", 32'(fifo_count), 32'((i < 2) ? i : (((i < 17) ? i : 17) - 1)));
    end
    @(posedge clk); #1 valid_in = 1'b0;
    wait_fd(300);
    chk("ready_at_done", 32'(ready_out), 32'd0);
    @(negedge clk);
    chk("ready_after_done", 32'(ready_out), 32'd1);
    wait_frames(fs0 + 17, 2000);
    chk("gapless_span", 32'(end_cyc[fs0+16] - start_cyc[fs0] + 1), 32'd1700);

    // Loopback byte patterns
    fs0 = frames_seen;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 data_in = lb[i]; valid_in = 1'b1; exp_q.push_back(lb[i]);
    end
    @(posedge clk); #1 valid_in = 1'b0;
    wait_frames(fs0 + 5, 700);

    // Reset during DATA bit 3 of 0xF0 with three bytes behind it
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 data_in = (i == 0) ? 8'hF0 : 8'(8'h11 * i); valid_in = 1'b1;
    end
    @(posedge clk); #1 valid_in = 1'b0;
    begin
      int t = 0;
      while (RsTx !== 1'b0 && t < 20) begin
        @(negedge clk);
        t++;
      end
    end
    chk("abort_start_seen", 32'(RsTx), 32'd0);
    repeat (44) @(negedge clk);
    chk("pre_reset_bit3", 32'(RsTx), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort_RsTx", 32'(RsTx), 32'd1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    fs0 = frames_seen;
    @(posedge clk); #1 data_in = 8'h3C; valid_in = 1'b1; exp_q.push_back(8'h3C);
    @(posedge clk); #1 valid_in = 1'b0;
    wait_frames(fs0 + 1, 200);
    repeat (150) @(negedge clk);
    chk("no_residue_frames", 32'(frames_seen), 32'(fs0 + 1));
    chk("no_residue_busy", 32'(busy), 32'd0);

    // Backpressure: full FIFO ignores changing data
    fs0 = frames_seen;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1 data_in = 8'(8'h40 + i); valid_in = 1'b1; exp_q.push_back(8'(8'h40 + i));
    end
    for (int j = 0; j < 30; j++) begin
      @(posedge clk); #1 data_in = 8'(8'hA0 + j);
      @(negedge clk);
      chk("bp_count", 32'(fifo_count), 32'd16);
      chk("bp_ready", 32'(ready_out), 32'd0);
    end
    @(posedge clk); #1 valid_in = 1'b0;
    wait_frames(fs0 + 17, 2000);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
